// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Handshake and data bundle between a requester (the CPU controller) and the
// iterative ALU.
//   start   requester -> ALU  request, sampled only while the ALU is idle
//   select  requester -> ALU  3-bit opcode, latched with start
//   data1   requester -> ALU  operand A / value to shift
//   data2   requester -> ALU  operand B / signed shift-rotate amount
//   busy    ALU -> requester  high while an operation is executing
//   done    ALU -> requester  one-cycle pulse, result/zero freshly written
//   result  ALU -> requester  registered result, held until the next done
//   zero    ALU -> requester  registered, result == 0
//   result_hi ALU -> requester upper product half (only with SEQ_ALU_MULT_HI_EN)
// Optional feature macro: SEQ_ALU_MULT_HI_EN
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
);
    logic                 start;
    logic [SEL_WIDTH-1:0] select;
    logic [WIDTH-1:0]     data1;
    logic [WIDTH-1:0]     data2;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 zero;
`ifdef SEQ_ALU_MULT_HI_EN
    logic [WIDTH-1:0]     result_hi;
`endif

    modport master (
        output start, select, data1, data2,
`ifdef SEQ_ALU_MULT_HI_EN
        input  result_hi,
`endif
        input  busy, done, result, zero
    );

    modport slave (
        input  start, select, data1, data2,
`ifdef SEQ_ALU_MULT_HI_EN
        output result_hi,
`endif
        output busy, done, result, zero
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU. Logic ops and add finish in one step; multiply runs
// shift-and-add one bit per step; shifts and rotates move one bit per step.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   seq_alu_if slave modport (start/select/data1/data2 in,
//         busy/done/result/zero[/result_hi] out)
// Parameters:
//   WIDTH      data width, power of two, >= 4
//   SEL_WIDTH  opcode width (3)
// Optional feature macro: SEQ_ALU_MULT_HI_EN -- when defined, the upper half
// of the 2*WIDTH multiply product is returned on bus.result_hi (0 for every
// other opcode). When undefined the upper half is simply discarded.
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
) (
    input logic        clk,
    input logic        rst,
    seq_alu_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);   // bits for an in-range amount
    localparam int CW = SW + 1;          // step counter must hold WIDTH itself

    localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];
    localparam logic [CW-1:0]    W_CNT = WIDTH[CW-1:0];
    localparam logic [CW-1:0]    ONE_CNT = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [SEL_WIDTH-1:0] OP_FWD  = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] OP_ADD  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] OP_AND  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] OP_OR   = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] OP_MULT = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] OP_SHL  = SEL_WIDTH'(5);
    localparam logic [SEL_WIDTH-1:0] OP_SHA  = SEL_WIDTH'(6);
    localparam logic [SEL_WIDTH-1:0] OP_ROT  = SEL_WIDTH'(7);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t                state_reg,  state_next;
    logic [SEL_WIDTH-1:0]  op_reg,     op_next;
    logic [WIDTH-1:0]      a_reg,      a_next;
    logic [WIDTH-1:0]      b_reg,      b_next;
    logic [CW-1:0]         cnt_reg,    cnt_next;
    logic                  right_reg,  right_next;   // shift/rotate toward LSB
    logic                  hold_reg,   hold_next;    // zero amount: pass data1
    logic [WIDTH-1:0]      work_reg,   work_next;    // shift/rotate datapath
    logic [2*WIDTH-1:0]    prod_reg,   prod_next;    // multiply accumulator
    logic [2*WIDTH-1:0]    mcand_reg,  mcand_next;   // multiplicand, moves left
    logic [WIDTH-1:0]      mplier_reg, mplier_next;  // multiplier, moves right
    logic                  done_reg,   done_next;
    logic [WIDTH-1:0]      result_reg, result_next;
    logic                  zero_reg,   zero_next;
`ifdef SEQ_ALU_MULT_HI_EN
    logic [WIDTH-1:0]      hi_reg,     hi_next;
`endif

    // Shift amount decode from the live data2 bus; only used on acceptance.
    // Negating the most negative value wraps to itself, which read unsigned is
    // exactly the required magnitude 2^(WIDTH-1).
    logic [WIDTH-1:0] mag;
    logic [SW-1:0]    rot_amt;
    logic [CW-1:0]    shift_steps;
    logic [CW-1:0]    rot_steps;

    always_comb begin
        mag = bus.data2[WIDTH-1] ? (~bus.data2 + {{(WIDTH-1){1'b0}}, 1'b1})
                                 : bus.data2;
        rot_amt = mag[SW-1:0];   // mod WIDTH, WIDTH being a power of two
        if (mag >= W_VAL) begin
            shift_steps = W_CNT;   // WIDTH single-bit moves flush every bit
        end else if (mag == '0) begin
            shift_steps = ONE_CNT;
        end else begin
            shift_steps = mag[CW-1:0];
        end
        rot_steps = (rot_amt == '0) ? ONE_CNT : {1'b0, rot_amt};
    end

    // One-bit step networks for the shift/rotate datapath.
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;
    logic [WIDTH-1:0] rol_v;
    logic [WIDTH-1:0] ror_v;
    logic             right_fill;

    // Arithmetic right shift keeps the MSB, which stays the original sign bit
    // across repeated single-bit steps.
    assign right_fill = (op_reg == OP_SHA) ? work_reg[WIDTH-1] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_lsb
                assign shl_v[gi] = 1'b0;
                assign rol_v[gi] = work_reg[WIDTH-1];
            end else begin : g_up
                assign shl_v[gi] = work_reg[gi-1];
                assign rol_v[gi] = work_reg[gi-1];
            end
            if (gi == WIDTH-1) begin : g_msb
                assign shr_v[gi] = right_fill;
                assign ror_v[gi] = work_reg[0];
            end else begin : g_dn
                assign shr_v[gi] = work_reg[gi+1];
                assign ror_v[gi] = work_reg[gi+1];
            end
        end
    endgenerate

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            right_reg  <= 1'b0;
            hold_reg   <= 1'b0;
            work_reg   <= '0;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            zero_reg   <= 1'b1;
`ifdef SEQ_ALU_MULT_HI_EN
            hi_reg     <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            right_reg  <= right_next;
            hold_reg   <= hold_next;
            work_reg   <= work_next;
            prod_reg   <= prod_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            done_reg   <= done_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
`ifdef SEQ_ALU_MULT_HI_EN
            hi_reg     <= hi_next;
`endif
        end
    end

    // Next-state and datapath update.
    logic [WIDTH-1:0]   final_val;
    logic [WIDTH-1:0]   work_step;
    logic [2*WIDTH-1:0] prod_step;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        right_next  = right_reg;
        hold_next   = hold_reg;
        work_next   = work_reg;
        prod_next   = prod_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        done_next   = 1'b0;
        result_next = result_reg;
        zero_next   = zero_reg;
`ifdef SEQ_ALU_MULT_HI_EN
        hi_next     = hi_reg;
`endif
        final_val   = '0;
        work_step   = work_reg;
        prod_step   = prod_reg;

        case (state_reg)
            IDLE: begin
                // Also reached in the done cycle, so a waiting request is
                // taken with no idle bubble.
                if (bus.start) begin
                    state_next  = EXEC;
                    op_next     = bus.select;
                    a_next      = bus.data1;
                    b_next      = bus.data2;
                    right_next  = bus.data2[WIDTH-1];
                    work_next   = bus.data1;
                    prod_next   = '0;
                    mcand_next  = {{WIDTH{1'b0}}, bus.data1};
                    mplier_next = bus.data2;
                    hold_next   = 1'b0;
                    case (bus.select)
                        OP_MULT: cnt_next = W_CNT;
                        OP_SHL, OP_SHA: begin
                            cnt_next  = shift_steps;
                            hold_next = (mag == '0);
                        end
                        OP_ROT: begin
                            cnt_next  = rot_steps;
                            hold_next = (rot_amt == '0);
                        end
                        default: cnt_next = ONE_CNT;
                    endcase
                end
            end

            EXEC: begin
                cnt_next = cnt_reg - ONE_CNT;
                case (op_reg)
                    OP_FWD: final_val = b_reg;
                    OP_ADD: final_val = a_reg + b_reg;
                    OP_AND: final_val = a_reg & b_reg;
                    OP_OR:  final_val = a_reg | b_reg;
                    OP_MULT: begin
                        prod_step   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
                        prod_next   = prod_step;
                        mcand_next  = mcand_reg << 1;
                        mplier_next = mplier_reg >> 1;
                        final_val   = prod_step[WIDTH-1:0];
                    end
                    OP_SHL, OP_SHA: begin
                        if (!hold_reg) begin
                            work_step = right_reg ? shr_v : shl_v;
                        end
                        work_next = work_step;
                        final_val = work_step;
                    end
                    default: begin   // OP_ROT
                        if (!hold_reg) begin
                            work_step = right_reg ? ror_v : rol_v;
                        end
                        work_next = work_step;
                        final_val = work_step;
                    end
                endcase

                if (cnt_reg == ONE_CNT) begin
                    state_next  = IDLE;
                    done_next   = 1'b1;
                    result_next = final_val;
                    zero_next   = (final_val == '0);
`ifdef SEQ_ALU_MULT_HI_EN
                    hi_next     = (op_reg == OP_MULT) ? prod_step[2*WIDTH-1:WIDTH] : '0;
`endif
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.busy   = (state_reg == EXEC);
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
    assign bus.zero   = zero_reg;
`ifdef SEQ_ALU_MULT_HI_EN
    assign bus.result_hi = hi_reg;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu at WIDTH=8: directed vector table, handshake
// corner sequences (ignored start, mid-operation reset, back-to-back ops) and
// random operations against a behavioural model. Result_hi is checked when
// SEQ_ALU_MULT_HI_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    seq_alu_if #(.WIDTH(W), .SEL_WIDTH(3)) bus ();

    seq_alu #(.WIDTH(W), .SEL_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        int           n;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model written straight from the opcode rules.
    function automatic void model(input logic [2:0] sel, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic [W-1:0] hi, output int n);
        int amt;
        int m;
        int k;
        logic [2*W-1:0] p;
        amt = b[W-1] ? int'(b) - (1 << W) : int'(b);
        m   = (amt < 0) ? -amt : amt;
        hi  = '0;
        n   = 1;
        res = '0;
        case (sel)
            3'd0: res = b;
            3'd1: res = a + b;
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: begin
                p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                res = p[W-1:0];
                hi  = p[2*W-1:W];
                n   = W;
            end
            3'd5, 3'd6: begin
                n = (m == 0) ? 1 : ((m > W) ? W : m);
                if (m == 0)            res = a;
                else if (amt > 0)      res = (m >= W) ? '0 : (a << m);
                else if (sel == 3'd5)  res = (m >= W) ? '0 : (a >> m);
                else                   res = (m >= W) ? {W{a[W-1]}} : ($signed(a) >>> m);
            end
            default: begin
                k = m % W;
                n = (k == 0) ? 1 : k;
                if (k == 0)       res = a;
                else if (amt > 0) res = (a << k) | (a >> (W - k));
                else              res = (a >> k) | (a << (W - k));
            end
        endcase
    endfunction

    // Issue one operation, scramble the inputs after acceptance, and check
    // latency, busy, result and zero.
    task automatic run_op(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic [W-1:0] exp_hi,
                          input int exp_n, input string tag);
        int cycles;
        bit got;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.select = sel;
        bus.data1  = a;
        bus.data2  = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.select = 3'($urandom);
        bus.data1  = W'($urandom);
        bus.data2  = W'($urandom);
        check({tag, " busy"}, 64'(bus.busy), 64'd1);
        cycles = 0;
        got    = 1'b0;
        while (cycles < 40 && !got) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done) got = 1'b1;
        end
        check({tag, " latency"}, got ? 64'(cycles) : 64'hFFFF, 64'(exp_n));
        check({tag, " result"}, 64'(bus.result), 64'(exp_res));
        check({tag, " zero"}, 64'(bus.zero), 64'(exp_res == '0));
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
`ifdef SEQ_ALU_MULT_HI_EN
        check({tag, " result_hi"}, 64'(bus.result_hi), 64'(exp_hi));
`endif
        $display("%s: sel=%b a=%h b=%h -> result=%h zero=%b cycles=%0d (want %h hi=%h n=%0d)",
                 tag, sel, a, b, bus.result, bus.zero, cycles, exp_res, exp_hi, exp_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r_res;
        logic [W-1:0] r_hi;
        int           r_n;
        logic [2:0]   r_sel;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic [W-1:0] cur_a;
        logic [W-1:0] cur_b;
        logic [W-1:0] exp_v;
        int           cycles;
        int           dones;
        bit           got;

        vecs[0]  = '{3'd0, 8'h12, 8'h34, 8'h34, 8'h00, 1};
        vecs[1]  = '{3'd1, 8'h05, 8'hFB, 8'h00, 8'h00, 1};
        vecs[2]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1};
        vecs[3]  = '{3'd3, 8'hF0, 8'h0C, 8'hFC, 8'h00, 1};
        vecs[4]  = '{3'd4, 8'h0C, 8'h0B, 8'h84, 8'h00, 8};
        vecs[5]  = '{3'd4, 8'h10, 8'h20, 8'h00, 8'h02, 8};
        vecs[6]  = '{3'd4, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8};
        vecs[7]  = '{3'd5, 8'h96, 8'hFE, 8'h25, 8'h00, 2};
        vecs[8]  = '{3'd6, 8'h96, 8'hFE, 8'hE5, 8'h00, 2};
        vecs[9]  = '{3'd5, 8'h96, 8'h0A, 8'h00, 8'h00, 8};
        vecs[10] = '{3'd5, 8'h96, 8'h80, 8'h00, 8'h00, 8};
        vecs[11] = '{3'd6, 8'h96, 8'h80, 8'hFF, 8'h00, 8};
        vecs[12] = '{3'd6, 8'h96, 8'h03, 8'hB0, 8'h00, 3};
        vecs[13] = '{3'd5, 8'h96, 8'h00, 8'h96, 8'h00, 1};
        vecs[14] = '{3'd7, 8'h81, 8'h09, 8'h03, 8'h00, 1};
        vecs[15] = '{3'd7, 8'h81, 8'h00, 8'h81, 8'h00, 1};
        vecs[16] = '{3'd7, 8'h81, 8'hFF, 8'hC0, 8'h00, 1};
        vecs[17] = '{3'd7, 8'h81, 8'h80, 8'h81, 8'h00, 1};
        vecs[18] = '{3'd7, 8'h96, 8'hFD, 8'hD2, 8'h00, 3};
        vecs[19] = '{3'd6, 8'h96, 8'hF9, 8'hFF, 8'h00, 7};
        vecs[20] = '{3'd5, 8'h01, 8'h07, 8'h80, 8'h00, 7};

        bus.start  = 1'b0;
        bus.select = '0;
        bus.data1  = '0;
        bus.data2  = '0;

        // Power-on reset state.
        rst = 1'b1;
        #2;
        check("reset busy",   64'(bus.busy),   64'd0);
        check("reset done",   64'(bus.done),   64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset zero",   64'(bus.zero),   64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Non-zero result, then an asynchronous reset pulse while idle.
        run_op(3'd3, 8'hF0, 8'h0C, 8'hFC, 8'h00, 1, "pre_reset_or");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("idle_reset busy",   64'(bus.busy),   64'd0);
        check("idle_reset done",   64'(bus.done),   64'd0);
        check("idle_reset result", 64'(bus.result), 64'd0);
        check("idle_reset zero",   64'(bus.zero),   64'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd1, 8'h05, 8'hFB, 8'h00, 8'h00, 1, "add_after_reset");

        // Directed vector table.
        for (int i = 0; i < 21; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].hi,
                   vecs[i].n, $sformatf("vec%0d", i));
        end

        // START pulsed during EXEC step 3 is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.select = 3'd4; bus.data1 = 8'h0C; bus.data2 = 8'h0B;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cycles = 0;
        got    = 1'b0;
        while (cycles < 40 && !got) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done) got = 1'b1;
            if (cycles == 2) begin
                bus.start = 1'b1; bus.select = 3'd1; bus.data1 = 8'h55; bus.data2 = 8'hAA;
            end else begin
                bus.start = 1'b0;
            end
        end
        check("ignore_start latency", got ? 64'(cycles) : 64'hFFFF, 64'd8);
        check("ignore_start result",  64'(bus.result), 64'h84);
        @(posedge clk);
        #1;
        check("ignore_start no_queue busy", 64'(bus.busy), 64'd0);
        check("ignore_start no_queue done", 64'(bus.done), 64'd0);
        $display("ignore_start: mult 0c*0b with start pulse at step 3 -> result=%h cycles=%0d",
                 bus.result, cycles);

        // Reset asserted at MULT step 4 aborts without DONE.
        @(negedge clk);
        bus.start = 1'b1; bus.select = 3'd4; bus.data1 = 8'h0C; bus.data2 = 8'h0B;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        rst = 1'b1;
        #1;
        check("abort busy",   64'(bus.busy),   64'd0);
        check("abort done",   64'(bus.done),   64'd0);
        check("abort result", 64'(bus.result), 64'd0);
        check("abort zero",   64'(bus.zero),   64'd1);
`ifdef SEQ_ALU_MULT_HI_EN
        check("abort result_hi", 64'(bus.result_hi), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        check("abort no_done", 64'(dones), 64'd0);
        $display("abort: reset at mult step 4 -> result=%h zero=%b busy=%b",
                 bus.result, bus.zero, bus.busy);

        // START held high with AND: each op accepted in the previous DONE cycle.
        @(negedge clk);
        cur_a = W'($urandom);
        cur_b = W'($urandom);
        bus.start = 1'b1; bus.select = 3'd2; bus.data1 = cur_a; bus.data2 = cur_b;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d busy", i), 64'(bus.busy), 64'd1);
            exp_v = cur_a & cur_b;
            r_a   = cur_a;
            r_b   = cur_b;
            cur_a = W'($urandom);
            cur_b = W'($urandom);
            if (i == 2) cur_b = ~cur_a;   // force a zero result in the stream
            bus.data1 = cur_a;
            bus.data2 = cur_b;
            @(posedge clk);
            #1;
            if (i == 7) bus.start = 1'b0;
            check($sformatf("b2b%0d done", i),   64'(bus.done),   64'd1);
            check($sformatf("b2b%0d result", i), 64'(bus.result), 64'(exp_v));
            check($sformatf("b2b%0d zero", i),   64'(bus.zero),   64'(exp_v == '0));
            $display("b2b%0d: and a=%h b=%h -> result=%h done=%b (want %h)",
                     i, r_a, r_b, bus.result, bus.done, exp_v);
        end
        @(posedge clk);
        #1;
        check("b2b end done", 64'(bus.done), 64'd0);
        check("b2b end busy", 64'(bus.busy), 64'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            r_sel = 3'($urandom_range(0, 7));
            r_a   = W'($urandom);
            if ($urandom_range(0, 1) == 1) r_b = W'(int'($urandom_range(0, 20)) - 10);
            else                           r_b = W'($urandom);
            model(r_sel, r_a, r_b, r_res, r_hi, r_n);
            run_op(r_sel, r_a, r_b, r_res, r_hi, r_n, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
